phy_tx: RTL

Transmit half of the GT PHY link layer. Accepts user frames on a 32-bit AXI-Stream slave port and serialises them onto the GT transceiver's 32-bit TX data/charisk interface. Each frame is wrapped as idle ordered set, SOF, payload, EOF. The framing is byte-exact with the format `phy_rx` decodes, so a `phy_tx` → `phy_rx` loopback returns every frame unchanged.

---
 rtl/phy_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/phy_tx.sv
// Transmit half of the GT PHY link layer: wraps AXI-Stream frames as
// idle / SOF / payload / EOF and serialises them onto the 32-bit GT TX lanes.
module phy_tx #(
    parameter int          P_GAP_WORDS = 2,
    parameter logic [7:0]  P_PAD_BYTE  = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_axi_s_valid,
    input  logic        i_axi_s_last,
    input  logic [3:0]  i_axi_s_keep,
    input  logic [31:0] i_axi_s_data,
    output logic        o_axi_s_ready,
    input  logic        i_gt_tx_done,
    output logic [31:0] o_gt_tx_data,
    output logic [3:0]  o_gt_tx_charisk,
    output logic        o_tx_underrun
);

    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_K    = 4'b0101;
    localparam logic [3:0]  GAP_LOAD  = 4'(P_GAP_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_TAIL,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] carry, carry_nxt;
    logic [1:0]  rem, rem_nxt;
    logic        underran, underran_nxt;
    logic [3:0]  gap_cnt, gap_nxt;
    logic [31:0] data_nxt;
    logic [3:0]  charisk_nxt;
    logic        underrun_nxt;
    logic [1:0]  last_rem;
    logic [31:0] tail_data;
    logic [3:0]  tail_k;
    logic [31:0] carry_ext;

    assign o_axi_s_ready = (state == S_SOF) || (state == S_DATA) || (state == S_DRAIN);

    // Index of the lane that will carry FD; keep 0000 falls into the 1-byte case.
    always_comb begin
        case (i_axi_s_keep)
            4'b1111: last_rem = 2'd3;
            4'b0111: last_rem = 2'd2;
            4'b0011: last_rem = 2'd1;
            default: last_rem = 2'd0;
        endcase
    end

    assign carry_ext = {P_PAD_BYTE, carry};

    always_comb begin
        tail_data = '0;
        tail_k    = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(rem)) begin
                tail_data[8*i +: 8] = carry_ext[8*i +: 8];
            end else if (i == int'(rem)) begin
                tail_data[8*i +: 8] = 8'hFD;
                tail_k[i]           = 1'b1;
            end else begin
                tail_data[8*i +: 8] = P_PAD_BYTE;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        carry_nxt    = carry;
        rem_nxt      = rem;
        underran_nxt = underran;
        gap_nxt      = gap_cnt;
        data_nxt     = o_gt_tx_data;
        charisk_nxt  = o_gt_tx_charisk;
        underrun_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                data_nxt    = IDLE_WORD;
                charisk_nxt = IDLE_K;
                if (i_axi_s_valid && i_gt_tx_done && (gap_cnt == 4'd0)) begin
                    state_nxt = S_SOF;
                end
            end
            S_SOF: begin
                data_nxt    = IDLE_WORD;
                charisk_nxt = IDLE_K;
                if (i_axi_s_valid) begin
                    data_nxt     = {i_axi_s_data[7:0], 8'hFB, 8'h50, 8'hBC};
                    charisk_nxt  = 4'b0101;
                    carry_nxt    = i_axi_s_data[31:8];
                    underran_nxt = 1'b0;
                    if (i_axi_s_last) begin
                        rem_nxt   = last_rem;
                        state_nxt = S_TAIL;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (i_axi_s_valid) begin
                    data_nxt    = {i_axi_s_data[7:0], carry};
                    charisk_nxt = 4'b0000;
                    carry_nxt   = i_axi_s_data[31:8];
                    if (i_axi_s_last) begin
                        rem_nxt   = last_rem;
                        state_nxt = S_TAIL;
                    end
                end else begin
                    // Upstream starved mid-frame: the wire holds its word, then EOF closes the frame.
                    rem_nxt      = 2'd3;
                    underran_nxt = 1'b1;
                    state_nxt    = S_TAIL;
                end
            end
            S_TAIL: begin
                data_nxt     = tail_data;
                charisk_nxt  = tail_k;
                underrun_nxt = underran;
                if (underran) begin
                    state_nxt = S_DRAIN;
                end else begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = S_GAP;
                end
            end
            S_DRAIN: begin
                data_nxt    = IDLE_WORD;
                charisk_nxt = IDLE_K;
                if (i_axi_s_valid && i_axi_s_last) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                data_nxt    = IDLE_WORD;
                charisk_nxt = IDLE_K;
                gap_nxt     = (gap_cnt != 4'd0) ? gap_cnt - 4'd1 : 4'd0;
                // The last mandatory idle may go straight to SOF so back-to-back frames see exactly the gap.
                if ((gap_cnt <= 4'd1) && i_gt_tx_done) begin
                    state_nxt = i_axi_s_valid ? S_SOF : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            carry           <= '0;
            rem             <= '0;
            underran        <= 1'b0;
            gap_cnt         <= '0;
            o_gt_tx_data    <= IDLE_WORD;
            o_gt_tx_charisk <= IDLE_K;
            o_tx_underrun   <= 1'b0;
        end else begin
            state           <= state_nxt;
            carry           <= carry_nxt;
            rem             <= rem_nxt;
            underran        <= underran_nxt;
            gap_cnt         <= gap_nxt;
            o_gt_tx_data    <= data_nxt;
            o_gt_tx_charisk <= charisk_nxt;
            o_tx_underrun   <= underrun_nxt;
        end
    end

endmodule
